// File: rtl/inv_delay_pkg.sv
// Shared widths and FSM state encoding for the inverter delay sequencer.
package inv_delay_pkg;
    localparam int CNT_W = 8;
    localparam int ACC_W = 12;
    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        DRIVE     = 3'd2,
        WAIT_EDGE = 3'd3,
        DONE      = 3'd4
    } state_t;
endpackage

// File: rtl/inv_delay_sequencer_sync2.sv
// Two-flop synchronizer for signals arriving asynchronously to clk.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate
endmodule

// File: rtl/inv_delay_sequencer.sv
// Inverter delay sequencer: toggles stim_out, times the synchronized response and
// accumulates the counts. Optional per-run min/max tracking under INVDLY_MINMAX_EN.
module inv_delay_sequencer
    import inv_delay_pkg::*;
#(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [IDX_W-1:0] n_meas,
    output logic             stim_out,
    input  logic             dut_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ACC_W-1:0] result,
    output logic [CNT_W-1:0] min_cnt,
    output logic [CNT_W-1:0] max_cnt
);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    logic dut_s;

    sync2 #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_in),
        .q     (dut_s)
    );

    state_t           state_reg,    state_next;
    logic             stim_reg,     stim_next;
    logic             busy_reg,     busy_next;
    logic             done_reg,     done_next;
    logic             err_reg,      err_next;
    logic [ACC_W-1:0] result_reg,   result_next;
    logic [CNT_W-1:0] cnt_reg,      cnt_next;
    logic [IDX_W-1:0] meas_idx_reg, meas_idx_next;
    logic [IDX_W-1:0] n_meas_reg,   n_meas_next;
    logic [SET_W-1:0] settle_reg,   settle_next;

    logic             accept;
    logic             resp_ok;
    logic             meas_hit;
    logic [CNT_W-1:0] cnt_inc;

    assign accept   = (state_reg == IDLE) && start && ena;
    assign resp_ok  = (dut_s != stim_reg);
    assign meas_hit = (state_reg == WAIT_EDGE) && ena && resp_ok;
    assign cnt_inc  = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next    = state_reg;
        stim_next     = stim_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        err_next      = err_reg;
        result_next   = result_reg;
        cnt_next      = cnt_reg;
        meas_idx_next = meas_idx_reg;
        n_meas_next   = n_meas_reg;
        settle_next   = settle_reg;

        if (!ena && (state_reg != IDLE)) begin
            // Abort keeps stim_out, result and err exactly as they were.
            state_next  = IDLE;
            busy_next   = 1'b0;
            settle_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        result_next   = '0;
                        err_next      = 1'b0;
                        cnt_next      = '0;
                        meas_idx_next = '0;
                        n_meas_next   = n_meas;
                        settle_next   = '0;
                        busy_next     = 1'b1;
                        state_next    = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_reg == SETTLE_LAST) begin
                        settle_next = '0;
                        if (resp_ok) begin
                            // stim_out flips on the edge into DRIVE, so an ideal
                            // inverter is captured at cnt=2 through the synchronizer.
                            stim_next  = ~stim_reg;
                            state_next = DRIVE;
                        end else begin
                            err_next   = 1'b1;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                            state_next = DONE;
                        end
                    end else begin
                        settle_next = settle_reg + SET_W'(1);
                    end
                end
                DRIVE: begin
                    cnt_next   = '0;
                    state_next = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    cnt_next = cnt_inc;
                    if (meas_hit) begin
                        result_next   = result_reg + ACC_W'(cnt_inc);
                        meas_idx_next = meas_idx_reg + IDX_W'(1);
                        if (meas_idx_reg == n_meas_reg) begin
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                            state_next = DONE;
                        end else begin
                            state_next = SETTLE;
                        end
                    end else if (cnt_inc == TIMEOUT_VAL) begin
                        err_next   = 1'b1;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            stim_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            result_reg   <= '0;
            cnt_reg      <= '0;
            meas_idx_reg <= '0;
            n_meas_reg   <= '0;
            settle_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            stim_reg     <= stim_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            result_reg   <= result_next;
            cnt_reg      <= cnt_next;
            meas_idx_reg <= meas_idx_next;
            n_meas_reg   <= n_meas_next;
            settle_reg   <= settle_next;
        end
    end

    assign stim_out = stim_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign result   = result_reg;

`ifdef INVDLY_MINMAX_EN
    logic [CNT_W-1:0] min_reg;
    logic [CNT_W-1:0] max_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_reg <= '0;
            max_reg <= '0;
        end else if (accept) begin
            min_reg <= '1;
            max_reg <= '0;
        end else if (meas_hit) begin
            if (cnt_inc < min_reg) min_reg <= cnt_inc;
            if (cnt_inc > max_reg) max_reg <= cnt_inc;
        end
    end

    assign min_cnt = min_reg;
    assign max_cnt = max_reg;
`else
    assign min_cnt = '0;
    assign max_cnt = '0;
`endif
endmodule

// File: tb/tb_inv_delay_sequencer.sv
// Self-checking bench for inv_delay_sequencer with a cycle-delayed inverter model
// and a run-level reference model of expected sums, extremes and run lengths.
module tb_inv_delay_sequencer;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 20;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic [3:0]  n_meas;
    logic        stim_out;
    logic        dut_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] result;
    logic [7:0]  min_cnt;
    logic [7:0]  max_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int   plan [16];
    int   tog_cnt = 0;
    int   base_tog = 0;
    int   k_idx;
    int   dly;
    logic [4:0]  tap;
    logic [31:0] hist = '0;
    logic stuck_en;
    logic stuck_val;
    logic exp_stim;

    inv_delay_sequencer #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .n_meas   (n_meas),
        .stim_out (stim_out),
        .dut_in   (dut_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .min_cnt  (min_cnt),
        .max_cnt  (max_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inverter model: output follows ~stim_out delayed by plan[k] whole clock cycles,
    // where k is the index of the measurement (toggle) within the current run.
    always @(posedge clk) hist <= {hist[30:0], stim_out};
    always @(stim_out) tog_cnt = tog_cnt + 1;

    always_comb begin
        k_idx = tog_cnt - base_tog - 1;
        if (k_idx < 0) k_idx = 0;
        if (k_idx > 15) k_idx = 15;
        dly = plan[k_idx];
        tap = 5'(dly - 1);
        if (stuck_en) dut_in = stuck_val;
        else if (dly == 0) dut_in = ~stim_out;
        else dut_in = ~hist[tap];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: each measurement costs SETTLE + 1 (drive) + (2 + delay) cycles.
    function automatic void model(input int n, output int res, output bit e, output int mn,
                                  output int mx, output int cyc, output int togs);
        int   c;
        logic lvl;
        res = 0; e = 0; mn = 255; mx = 0; cyc = 0; togs = 0;
        for (int k = 0; k <= n; k++) begin
            lvl = exp_stim ^ togs[0];
            if (stuck_en && (stuck_val == lvl)) begin
                e = 1; cyc += SETTLE;
                break;
            end
            togs++;
            c = stuck_en ? 1000 : 2 + plan[k];
            if (c > TIMEOUT) begin
                e = 1; cyc += SETTLE + 1 + TIMEOUT;
                break;
            end
            res += c;
            if (c < mn) mn = c;
            if (c > mx) mx = c;
            cyc += SETTLE + 1 + c;
        end
    endfunction

    task automatic do_run(input string tag, input int n, input bit repulse);
        int e_res, e_mn, e_mx, e_cyc, e_tog, cyc;
        bit e_err, got, busy_ok;
        model(n, e_res, e_err, e_mn, e_mx, e_cyc, e_tog);
        base_tog = tog_cnt;
        @(negedge clk);
        start  = 1'b1;
        n_meas = 4'(n);
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        n_meas = 4'(~n);
        chk({tag, ".busy_on"}, 32'(busy), 1);
        busy_ok = 1; got = 0; cyc = 0;
        while (!got && cyc < e_cyc + 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (repulse) start = (cyc == 6);
            if (done) got = 1;
            else if (!busy) busy_ok = 0;
        end
        start = 1'b0;
        exp_stim = exp_stim ^ e_tog[0];
        chk({tag, ".done_seen"}, 32'(got), 1);
        chk({tag, ".cycles"}, cyc, e_cyc);
        chk({tag, ".busy_held"}, 32'(busy_ok), 1);
        chk({tag, ".busy_at_done"}, 32'(busy), 0);
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        chk({tag, ".result"}, 32'(result), e_res);
        chk({tag, ".stim"}, 32'(stim_out), 32'(exp_stim));
`ifdef INVDLY_MINMAX_EN
        chk({tag, ".min"}, 32'(min_cnt), e_mn);
        chk({tag, ".max"}, 32'(max_cnt), e_mx);
`else
        chk({tag, ".min"}, 32'(min_cnt), 0);
        chk({tag, ".max"}, 32'(max_cnt), 0);
`endif
        @(negedge clk);
        chk({tag, ".done_single"}, 32'(done), 0);
        repeat (3) @(negedge clk);
        chk({tag, ".idle_busy"}, 32'(busy), 0);
        chk({tag, ".result_hold"}, 32'(result), e_res);
        chk({tag, ".err_hold"}, 32'(err), 32'(e_err));
    endtask

    initial begin
        bit saw;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; n_meas = '0;
        stuck_en = 1'b0; stuck_val = 1'b0; exp_stim = 1'b0;
        for (int k = 0; k < 16; k++) plan[k] = 0;

        #3;
        chk("rst.stim", 32'(stim_out), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.result", 32'(result), 0);
        chk("rst.minmax", {16'd0, min_cnt, max_cnt}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset in the middle of a run, after one measurement has completed.
        base_tog = tog_cnt;
        @(negedge clk); start = 1'b1; n_meas = 4'd3;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("midrst.busy_pre", 32'(busy), 1);
        chk("midrst.result_pre", 32'(result), 2);
        chk("midrst.stim_pre", 32'(stim_out), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.stim", 32'(stim_out), 0);
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.err", 32'(err), 0);
        chk("midrst.result", 32'(result), 0);
        chk("midrst.minmax", {16'd0, min_cnt, max_cnt}, 0);
        saw = 0;
        repeat (4) begin @(negedge clk); if (done) saw = 1; end
        chk("midrst.no_done", 32'(saw), 0);
        rst_n = 1'b1;
        exp_stim = 1'b0;
        repeat (20) @(negedge clk);

        for (int k = 0; k < 16; k++) plan[k] = 0;
        do_run("zero_dly", 3, 0);
        repeat (20) @(negedge clk);

        for (int k = 0; k < 16; k++) plan[k] = 3;
        do_run("dly3_repulse", 3, 1);
        repeat (20) @(negedge clk);

        stuck_en = 1'b1; stuck_val = exp_stim;
        do_run("stuck", 0, 0);
        stuck_en = 1'b0;
        repeat (20) @(negedge clk);

        plan[0] = 30;
        do_run("timeout", 0, 0);
        repeat (40) @(negedge clk);

        plan[0] = 18;
        do_run("edge_at_limit", 0, 0);
        repeat (40) @(negedge clk);
        plan[0] = 19;
        do_run("edge_past_limit", 0, 0);
        repeat (40) @(negedge clk);

        // ena dropped during the second measurement's WAIT_EDGE.
        for (int k = 0; k < 16; k++) plan[k] = 5;
        base_tog = tog_cnt;
        @(negedge clk); start = 1'b1; n_meas = 4'd3;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (27) @(posedge clk);
        @(negedge clk);
        chk("abort.busy_pre", 32'(busy), 1);
        chk("abort.result_pre", 32'(result), 7);
        ena = 1'b0;
        @(negedge clk);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.done", 32'(done), 0);
        chk("abort.result", 32'(result), 7);
        chk("abort.err", 32'(err), 0);
        chk("abort.stim", 32'(stim_out), 32'(exp_stim));
        saw = 0;
        repeat (10) begin @(negedge clk); if (done || busy) saw = 1; end
        chk("abort.stays_idle", 32'(saw), 0);
        ena = 1'b1;
        repeat (20) @(negedge clk);

        plan[0] = 0; plan[1] = 4;
        do_run("minmax_alt", 1, 0);
        repeat (20) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 16; k++) plan[k] = $urandom_range(0, 10);
            plan[0] = $urandom_range(0, 17);
            do_run($sformatf("rand%0d", r), $urandom_range(0, 15), 0);
            repeat (20) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
